// File: rtl/coh_pkg.sv
// Shared MSI coherence definitions: line states, bus/response codes and the
// snoop FSM state type, imported by both the processor-side and bus-side controllers.
package coh_pkg;

   typedef enum logic [1:0] {
      ST_INVALID   = 2'b00,
      ST_EXCLUSIVE = 2'b01,
      ST_SHARED    = 2'b10
   } line_state_t;

   localparam logic [2:0] MSG_EMPTY      = 3'b000;
   localparam logic [2:0] MSG_READ_MISS  = 3'b001;
   localparam logic [2:0] MSG_INVALIDATE = 3'b010;
   localparam logic [2:0] MSG_WRITE_MISS = 3'b011;

   localparam logic [2:0] RSP_WRITE_BACK_BLOCK       = 3'b100;
   localparam logic [2:0] RSP_WRITE_BACK_CACHE_BLOCK = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE      = 2'b00,
      S_LOOKUP    = 2'b01,
      S_WRITEBACK = 2'b10
   } snoop_state_t;

   // Code 11 has no meaning in MSI; treat it as an empty line.
   function automatic line_state_t norm_state(input logic [1:0] code);
      line_state_t s;
      case (code)
         2'b01:   s = ST_EXCLUSIVE;
         2'b10:   s = ST_SHARED;
         default: s = ST_INVALID;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/snoop_line_store.sv
// Direct-mapped tag/state store: CPU write port, snoop state-write port,
// a combinational CPU read of the state and a combinational lookup read.
module snoop_line_store
   import coh_pkg::*;
#(
   parameter int  NUM_LINES = 4,
   parameter int  TAG_W     = 8,
   localparam int IDX_W     = $clog2(NUM_LINES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_we,
   input  logic [IDX_W-1:0]  cpu_idx,
   input  logic [TAG_W-1:0]  cpu_tag,
   input  line_state_t       cpu_state,
   input  logic              snp_we,
   input  logic [IDX_W-1:0]  snp_idx,
   input  line_state_t       snp_state,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [1:0]        rd_state,
   input  logic [IDX_W-1:0]  lk_idx,
   output line_state_t       lk_state,
   output logic [TAG_W-1:0]  lk_tag
);

   line_state_t      st_q  [NUM_LINES];
   logic [TAG_W-1:0] tag_q [NUM_LINES];

   // Snoop write is ordered last so it wins if both ever target the same line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_LINES; i++) begin
            st_q[i]  <= ST_INVALID;
            tag_q[i] <= '0;
         end
      end else begin
         if (cpu_we) begin
            st_q[cpu_idx]  <= cpu_state;
            tag_q[cpu_idx] <= cpu_tag;
         end
         if (snp_we) begin
            st_q[snp_idx] <= snp_state;
         end
      end
   end

   assign rd_state = st_q[rd_idx];
   assign lk_state = st_q[lk_idx];
   assign lk_tag   = tag_q[lk_idx];

endmodule

// File: rtl/snoop_responder.sv
// Bus-side MSI snoop responder: reacts to remote read/write misses and invalidates.
// Optional SNOOP_STATS_EN adds saturating hit and write-back counters.
//
// state     | meaning
// IDLE      | ready for a bus message; message/address latched on accept
// LOOKUP    | one cycle: compare latched tag with the store, decide outcome
// WRITEBACK | owned line being flushed; wait for wb_ready, then apply new state
module snoop_responder
   import coh_pkg::*;
#(
   parameter int  NUM_LINES = 4,
   parameter int  TAG_W     = 8,
   localparam int IDX_W     = $clog2(NUM_LINES),
   localparam int ADDR_W    = TAG_W + IDX_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bus_valid,
   output logic              bus_ready,
   input  logic [2:0]        bus_msg,
   input  logic [ADDR_W-1:0] bus_addr,
   output logic              snoop_done,
   output logic              abort_mem,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [ADDR_W-1:0] wb_addr,
   input  logic              cpu_upd_valid,
   output logic              cpu_upd_ready,
   input  logic [IDX_W-1:0]  cpu_upd_idx,
   input  logic [TAG_W-1:0]  cpu_upd_tag,
   input  logic [1:0]        cpu_upd_state,
   input  logic [IDX_W-1:0]  cpu_rd_idx,
   output logic [1:0]        cpu_rd_state,
`ifdef SNOOP_STATS_EN
   output logic [15:0]       stat_hits,
   output logic [15:0]       stat_wbs,
`endif
   output logic              proto_err
);

   snoop_state_t     state_q, state_d;
   logic [2:0]       lat_msg;
   logic [TAG_W-1:0] lat_tag;
   logic [IDX_W-1:0] lat_idx;
   line_state_t      pend_q, pend_d;
   logic [ADDR_W-1:0] wb_addr_q;
   logic             proto_q;

   logic             latch;
   logic             go_wb;
   logic             set_err;
   logic             snp_we;
   line_state_t      snp_state;
   line_state_t      lk_state;
   logic [TAG_W-1:0] lk_tag;
   logic             hit;
   logic             msg_valid;
   logic             cpu_we;

   assign cpu_upd_ready = !(state_q != S_IDLE && cpu_upd_idx == lat_idx);
   assign cpu_we        = cpu_upd_valid && cpu_upd_ready;

   snoop_line_store #(
      .NUM_LINES (NUM_LINES),
      .TAG_W     (TAG_W)
   ) u_store (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_we    (cpu_we),
      .cpu_idx   (cpu_upd_idx),
      .cpu_tag   (cpu_upd_tag),
      .cpu_state (norm_state(cpu_upd_state)),
      .snp_we    (snp_we),
      .snp_idx   (lat_idx),
      .snp_state (snp_state),
      .rd_idx    (cpu_rd_idx),
      .rd_state  (cpu_rd_state),
      .lk_idx    (lat_idx),
      .lk_state  (lk_state),
      .lk_tag    (lk_tag)
   );

   assign hit       = (lk_state != ST_INVALID) && (lk_tag == lat_tag);
   assign msg_valid = (lat_msg == MSG_READ_MISS) || (lat_msg == MSG_INVALIDATE) ||
                      (lat_msg == MSG_WRITE_MISS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         lat_msg   <= MSG_EMPTY;
         lat_tag   <= '0;
         lat_idx   <= '0;
         pend_q    <= ST_INVALID;
         wb_addr_q <= '0;
         proto_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         if (latch) begin
            lat_msg <= bus_msg;
            lat_tag <= bus_addr[ADDR_W-1:IDX_W];
            lat_idx <= bus_addr[IDX_W-1:0];
         end
         if (go_wb) begin
            wb_addr_q <= {lat_tag, lat_idx};
         end
         if (set_err) begin
            proto_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      bus_ready  = 1'b0;
      snoop_done = 1'b0;
      abort_mem  = 1'b0;
      wb_valid   = 1'b0;
      latch      = 1'b0;
      go_wb      = 1'b0;
      set_err    = 1'b0;
      snp_we     = 1'b0;
      snp_state  = ST_INVALID;
      case (state_q)
         S_IDLE: begin
            bus_ready = 1'b1;
            if (bus_valid) begin
               latch   = 1'b1;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            state_d = S_IDLE;
            if (!hit || !msg_valid) begin
               snoop_done = 1'b1;
            end else if (lk_state == ST_SHARED) begin
               snoop_done = 1'b1;
               snp_we     = (lat_msg != MSG_READ_MISS);
            end else if (lat_msg == MSG_INVALIDATE) begin
               // Another cache cannot hold a copy of a line we own exclusively.
               set_err    = 1'b1;
               snp_we     = 1'b1;
               snoop_done = 1'b1;
            end else begin
               abort_mem = 1'b1;
               go_wb     = 1'b1;
               pend_d    = (lat_msg == MSG_READ_MISS) ? ST_SHARED : ST_INVALID;
               state_d   = S_WRITEBACK;
            end
         end
         S_WRITEBACK: begin
            wb_valid = 1'b1;
            if (wb_ready) begin
               snp_we     = 1'b1;
               snp_state  = pend_q;
               snoop_done = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign wb_addr   = wb_addr_q;
   assign proto_err = proto_q;

`ifdef SNOOP_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_hits <= '0;
         stat_wbs  <= '0;
      end else begin
         if (state_q == S_LOOKUP && hit && stat_hits != 16'hFFFF) begin
            stat_hits <= stat_hits + 16'd1;
         end
         if (state_q == S_WRITEBACK && wb_ready && stat_wbs != 16'hFFFF) begin
            stat_wbs <= stat_wbs + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// Scoreboard bench for snoop_responder: directed MSI cases, randomized traffic
// against a line-state model, and an asynchronous reset during a write-back.
module tb_snoop_responder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       bus_valid;
   logic       bus_ready;
   logic [2:0] bus_msg;
   logic [9:0] bus_addr;
   logic       snoop_done;
   logic       abort_mem;
   logic       wb_valid;
   logic       wb_ready;
   logic [9:0] wb_addr;
   logic       cpu_upd_valid;
   logic       cpu_upd_ready;
   logic [1:0] cpu_upd_idx;
   logic [7:0] cpu_upd_tag;
   logic [1:0] cpu_upd_state;
   logic [1:0] cpu_rd_idx;
   logic [1:0] cpu_rd_state;
   logic       proto_err;
`ifdef SNOOP_STATS_EN
   logic [15:0] stat_hits;
   logic [15:0] stat_wbs;
`endif

   snoop_responder #(.NUM_LINES(4), .TAG_W(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus_valid     (bus_valid),
      .bus_ready     (bus_ready),
      .bus_msg       (bus_msg),
      .bus_addr      (bus_addr),
      .snoop_done    (snoop_done),
      .abort_mem     (abort_mem),
      .wb_valid      (wb_valid),
      .wb_ready      (wb_ready),
      .wb_addr       (wb_addr),
      .cpu_upd_valid (cpu_upd_valid),
      .cpu_upd_ready (cpu_upd_ready),
      .cpu_upd_idx   (cpu_upd_idx),
      .cpu_upd_tag   (cpu_upd_tag),
      .cpu_upd_state (cpu_upd_state),
      .cpu_rd_idx    (cpu_rd_idx),
      .cpu_rd_state  (cpu_rd_state),
`ifdef SNOOP_STATS_EN
      .stat_hits     (stat_hits),
      .stat_wbs      (stat_wbs),
`endif
      .proto_err     (proto_err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         wb;
      logic [9:0] addr;
      int         acc;
      int         lat;
      bit         err_before;
   } exp_t;
   exp_t sb[$];
   bit abort_seen = 0;
   bit wb_seen    = 0;

   // Reference model: MSI line states, tags and the sticky error flag.
   logic [1:0] m_st  [4];
   logic [7:0] m_tag [4];
   bit         m_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   function automatic logic [1:0] norm(input logic [1:0] s);
      return (s == 2'b11) ? 2'b00 : s;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         m_st[i]  = 2'b00;
         m_tag[i] = 8'h00;
      end
      m_err = 0;
   endtask

   // Monitor: every observed output event is checked against the queue head.
   always @(negedge clk) begin
      if (rst_n) begin
         if (abort_mem) begin
            if (sb.size() == 0) fail_now("abort_orphan");
            else begin
               abort_seen = 1;
               chk("abort_cycle", cyc - sb[0].acc, 1);
            end
         end
         if (wb_valid) begin
            if (sb.size() == 0) fail_now("wb_orphan");
            else begin
               wb_seen = 1;
               chk("wb_addr", wb_addr, sb[0].addr);
               chk("wb_expected", 1, sb[0].wb);
            end
         end
         if (snoop_done) begin
            if (sb.size() == 0) fail_now("done_orphan");
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("done_latency", cyc - e.acc, e.lat);
               chk("abort_seen", abort_seen, e.wb);
               chk("wb_seen", wb_seen, e.wb);
               chk("proto_at_done", proto_err, e.err_before);
               abort_seen = 0;
               wb_seen    = 0;
            end
         end
      end
   end

   task automatic check_lines(input string name);
      for (int i = 0; i < 4; i++) begin
         cpu_rd_idx = 2'(i);
         #1;
         chk(name, cpu_rd_state, m_st[i]);
      end
      chk("proto_err", proto_err, m_err);
   endtask

   task automatic cpu_write(input logic [1:0] idx, input logic [7:0] tag, input logic [1:0] st);
      @(posedge clk); #1;
      cpu_upd_valid = 1; cpu_upd_idx = idx; cpu_upd_tag = tag; cpu_upd_state = st;
      #1;
      chk("cpu_ready_idle", cpu_upd_ready, 1);
      @(posedge clk); #1;
      cpu_upd_valid = 0;
      m_st[idx]  = norm(st);
      m_tag[idx] = tag;
   endtask

   task automatic side_upd(input logic [1:0] bidx, input logic [1:0] sidx,
                           input logic [7:0] stag, input logic [1:0] sst);
      cpu_upd_valid = 1; cpu_upd_idx = sidx; cpu_upd_tag = stag; cpu_upd_state = sst;
      #1;
      chk("cpu_ready_busy", cpu_upd_ready, sidx != bidx);
      if (sidx != bidx) begin
         m_st[sidx]  = norm(sst);
         m_tag[sidx] = stag;
      end
   endtask

   // Issues one bus message, pushes the expected outcome and drives wb_ready.
   task automatic txn(input logic [2:0] msg, input logic [7:0] tag, input logic [1:0] idx,
                      input int d, input bit same, input logic [7:0] same_tag,
                      input logic [1:0] same_st, input bit side, input logic [1:0] sidx,
                      input logic [7:0] stag, input logic [1:0] sst);
      int   n;
      logic [1:0] st;
      logic [1:0] nxt;
      bit   hit, wb, err;
      exp_t e;
      @(posedge clk); #1;
      n = 0;
      while (!bus_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus_ready) fail_now("bus_ready_timeout");
      bus_valid = 1; bus_msg = msg; bus_addr = {tag, idx};
      if (same) begin
         cpu_upd_valid = 1; cpu_upd_idx = idx; cpu_upd_tag = same_tag; cpu_upd_state = same_st;
         m_st[idx]  = norm(same_st);
         m_tag[idx] = same_tag;
      end
      st  = m_st[idx];
      hit = (st != 2'b00) && (m_tag[idx] == tag);
      wb  = 0; err = 0; nxt = st;
      if (hit && (msg == 3'd1 || msg == 3'd2 || msg == 3'd3)) begin
         if (st == 2'b10) begin
            if (msg != 3'd1) nxt = 2'b00;
         end else if (msg == 3'd2) begin
            nxt = 2'b00; err = 1;
         end else begin
            wb = 1;
            nxt = (msg == 3'd1) ? 2'b10 : 2'b00;
         end
      end
      e.wb = wb; e.addr = {tag, idx}; e.acc = cyc; e.lat = wb ? 2 + d : 1;
      e.err_before = m_err;
      sb.push_back(e);
      m_st[idx] = nxt;
      if (err) m_err = 1;
      @(posedge clk); #1;
      bus_valid = 0; cpu_upd_valid = 0; wb_ready = 1'($urandom % 2);
      if (!wb) begin
         if (side) side_upd(idx, sidx, stag, sst);
         @(posedge clk); #1;
         cpu_upd_valid = 0; wb_ready = 0;
      end else begin
         @(posedge clk); #1;
         wb_ready = (d == 0);
         if (side) side_upd(idx, sidx, stag, sst);
         for (int i = 0; i < d; i++) begin
            @(posedge clk); #1;
            cpu_upd_valid = 0;
            wb_ready = (i == d - 1);
         end
         @(posedge clk); #1;
         wb_ready = 0; cpu_upd_valid = 0;
      end
      check_lines("line_state");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] pool [3];
      pool[0] = 8'h5A; pool[1] = 8'h33; pool[2] = 8'hC4;
      rst_n = 0; bus_valid = 0; bus_msg = 0; bus_addr = 0; wb_ready = 0;
      cpu_upd_valid = 0; cpu_upd_idx = 0; cpu_upd_tag = 0; cpu_upd_state = 0; cpu_rd_idx = 0;
      model_clear();
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk);
      check_lines("reset_line");
      chk("reset_bus_ready", bus_ready, 1);
      chk("reset_done", snoop_done, 0);
      chk("reset_abort", abort_mem, 0);
      chk("reset_wb_valid", wb_valid, 0);
      chk("reset_wb_addr", wb_addr, 0);

      // Shared line hit by a write miss: invalidated, no write-back.
      cpu_write(2'd1, 8'h5A, 2'b10);
      txn(3'd3, 8'h5A, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0);
      // Owned line read by another cache: abort, 3-cycle stalled write-back, goes Shared.
      cpu_write(2'd2, 8'h33, 2'b01);
      txn(3'd1, 8'h33, 2'd2, 3, 0, 0, 0, 1, 2'd2, 8'h99, 2'b01);
      // Tag mismatch on the same index.
      txn(3'd1, 8'h77, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0);
      // Invalidate against an owned line is a protocol error.
      cpu_write(2'd3, 8'h11, 2'b01);
      txn(3'd2, 8'h11, 2'd3, 0, 0, 0, 0, 0, 0, 0, 0);
      // Same-cycle CPU write to the snooped index lands first.
      txn(3'd3, 8'hC4, 2'd0, 1, 1, 8'hC4, 2'b01, 1, 2'd1, 8'h5A, 2'b10);

      for (int k = 0; k < 150; k++) begin
         logic [1:0] idx;
         logic [2:0] msg;
         idx = 2'($urandom % 4);
         msg = ($urandom % 10 < 9) ? 3'(1 + $urandom % 3) : 3'($urandom % 8);
         if ($urandom % 2 == 0)
            cpu_write(2'($urandom % 4), pool[$urandom % 3], 2'($urandom % 4));
         txn(msg, pool[$urandom % 3], idx, int'($urandom % 4),
             ($urandom % 5) == 0, pool[$urandom % 3], 2'($urandom % 4),
             ($urandom % 3) == 0, 2'($urandom % 4), pool[$urandom % 3], 2'($urandom % 4));
      end

      // Reset in the middle of a write-back.
      cpu_write(2'd2, 8'h33, 2'b01);
      @(posedge clk); #1;
      bus_valid = 1; bus_msg = 3'd1; bus_addr = {8'h33, 2'd2};
      begin
         exp_t e;
         e.wb = 1; e.addr = {8'h33, 2'd2}; e.acc = cyc; e.lat = 0; e.err_before = m_err;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      bus_valid = 0;
      @(posedge clk); #1;
      chk("wb_valid_held", wb_valid, 1);
      side_upd(2'd2, 2'd2, 8'hEE, 2'b10);
      side_upd(2'd2, 2'd0, 8'h42, 2'b10);
      @(posedge clk); #1;
      cpu_upd_valid = 0;
      cpu_rd_idx = 2'd0;
      #1;
      chk("upd_during_wb", cpu_rd_state, m_st[0]);
      rst_n = 0;
      #1;
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_bus_ready", bus_ready, 1);
      chk("rst_done", snoop_done, 0);
      chk("rst_abort", abort_mem, 0);
      sb.delete();
      abort_seen = 0;
      wb_seen    = 0;
      model_clear();
      check_lines("rst_line");
      @(posedge clk); #1;
      rst_n = 1;
      // Fresh transaction after reset must still work.
      txn(3'd1, 8'h00, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      chk("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/snoop_responder.md
Name: snoop_responder

Overview:
- Bus-side half of the per-processor MSI snooping controller. It receives coherence messages that other processors place on the shared bus (read miss, write miss, invalidate) and updates the local line-state/tag store.
- It issues write-backs and memory-abort when the local copy is Exclusive (owned/dirty).
- It sits beside the processor-side FSM, which writes line states through the cpu_upd port.

Parameters:
- NUM_LINES, 4, number of direct-mapped cache lines; power of 2, at least 2.
- TAG_W, 8, tag width in bits.
- IDX_W is a derived localparam, clog2(NUM_LINES). Address width is TAG_W+IDX_W; the index occupies the low bits.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous reset, active-low.
- bus_valid  in  1  a bus message is present.
- bus_ready  out  1  responder can accept a message; high only in IDLE.
- bus_msg  in  3  001 Read_Miss, 010 Invalidate, 011 Write_Miss; any other code is a no-op.
- bus_addr  in  TAG_W+IDX_W  block address.
- snoop_done  out  1  one-cycle pulse when a transaction completes.
- abort_mem  out  1  one-cycle pulse in LOOKUP when the local line is Exclusive and hit; memory must not answer.
- wb_valid  out  1  write-back request.
- wb_ready  in  1  memory accepts the write-back.
- wb_addr  out  TAG_W+IDX_W  block being written back.
- cpu_upd_valid  in  1  processor-side state write.
- cpu_upd_ready  out  1  state write accepted.
- cpu_upd_idx  in  IDX_W  line index.
- cpu_upd_tag  in  TAG_W  tag to store.
- cpu_upd_state  in  2  00 Invalid, 01 Exclusive, 10 Shared.
- cpu_rd_idx  in  IDX_W  combinational read index.
- cpu_rd_state  out  2  state of line cpu_rd_idx.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, rst_n low):
  - All line states go to Invalid (00); all tags go to 0.
  - FSM goes to IDLE.
  - snoop_done, abort_mem, wb_valid and proto_err go to 0; wb_addr goes to 0.
  - Reset mid-transaction discards the transaction; no partial state update survives.
- FSM states: IDLE, LOOKUP, WRITEBACK.
- IDLE:
  - bus_ready=1.
  - On bus_valid&&bus_ready: latch msg/addr and go to LOOKUP.
- LOOKUP (one cycle):
  - hit = state[idx]!=Invalid && tag[idx]==lat_tag.
  - Miss, or a no-op code: snoop_done=1, no change, go to IDLE.
  - Shared + Read_Miss: stay Shared; snoop_done; go to IDLE.
  - Shared + Write_Miss or Invalidate: line goes to Invalid; snoop_done; go to IDLE.
  - Exclusive + Read_Miss: abort_mem=1; go to WRITEBACK; next state Shared.
  - Exclusive + Write_Miss: abort_mem=1; go to WRITEBACK; next state Invalid.
  - Exclusive + Invalidate: illegal. Set proto_err, line goes to Invalid, snoop_done, go to IDLE. No write-back.
- WRITEBACK:
  - wb_valid=1 with wb_addr={tag,idx}, held stable until wb_ready.
  - In the handshake cycle: apply the pending next state, pulse snoop_done, go to IDLE.
  - wb_ready while wb_valid=0 is ignored.
- Latency: a non-write-back transaction completes 1 cycle after accept (done in the LOOKUP cycle). A write-back transaction completes at least 2 cycles after accept.
- Back-to-back: bus_ready reasserts in the cycle after snoop_done.
- CPU update port:
  - cpu_upd_ready = !(FSM!=IDLE && cpu_upd_idx==lat_idx).
  - An accepted write updates tag and state at posedge.
  - Updates to other indices proceed during a snoop.
  - A CPU write in the same cycle as bus acceptance of the same index is allowed. The CPU write lands first; the snoop then looks up the new contents.
- cpu_rd_state is combinational from the state array.
- State code 11 written by the CPU is stored as Invalid.

Optional Feature:
- Macro SNOOP_STATS_EN.
- When defined, adds two outputs:
  - stat_hits [15:0]: counts LOOKUP hits.
  - stat_wbs [15:0]: counts write-back handshakes.
  - Both saturate at FFFF and clear on reset.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package coh_pkg holds:
  - state codes Invalid/Exclusive/Shared;
  - bus message codes 001/010/011 and Empty=000;
  - response codes Write_Back_Block=100 and Write_Back_Cache_Block=101;
  - the FSM-state typedef.
- The processor-side FSM and this block both import coh_pkg.
- One natural sub-module: snoop_line_store. It holds the tag/state arrays with the CPU write port, the snoop write port and the combinational read; this block owns the write priority.

Test Plan:
- Reset, then cpu_rd_idx 0..3: cpu_rd_state=00 for every line; bus_ready=1; all pulses 0.
- CPU writes idx1 tag 0x5A Shared; bus Write_Miss addr {0x5A,1}: snoop_done 1 cycle after accept; abort_mem=0; wb_valid never rises; cpu_rd_state(1)=00.
- CPU writes idx2 tag 0x33 Exclusive; bus Read_Miss {0x33,2}; wb_ready held low 3 cycles: abort_mem pulses in LOOKUP; wb_valid=1 and wb_addr={0x33,2} stable for 3 cycles; on wb_ready, snoop_done pulses and state(2)=10.
- Bus Read_Miss {0x77,2} against stored tag 0x33: miss, snoop_done after 1 cycle, state(2) unchanged.
- Line idx3 Exclusive, bus Invalidate {tag,3}: proto_err=1 and stays 1; state(3)=00; no write-back.
- During WRITEBACK on idx2: CPU update to idx2 sees cpu_upd_ready=0; CPU update to idx0 accepted. Assert rst_n low mid-write-back: wb_valid drops immediately and all states read 00.
